cbs_result_writer: RTL and testbench

// - Write-back end of the CBS pipeline: accepts the conv accumulator stream produced from the 3x3 padded windows,

---
 rtl/cbs_pkg.sv | 11 +
 rtl/cbs_result_writer_if.sv | 28 ++
 rtl/cbs_wb_quant.sv | 45 ++++
 rtl/cbs_result_writer.sv | 75 +++++++
 tb/tb_cbs_result_writer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/cbs_pkg.sv
// cbs_pkg: shared CBS write-back geometry, widths and FSM state type
package cbs_pkg;
  localparam int IMG_W = 640;
  localparam int IMG_H = 640;
  localparam int ACC_W = 24;
  localparam int SC_W = 16;
  localparam int ADDR_W = 25;
  localparam int PIX_W = 8;
  localparam int PIX_MAX = 255;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} wb_state_t;
endpackage

// File: rtl/cbs_result_writer_if.sv
// cbs_result_writer_if: control, result stream and output-memory write port of the CBS writer
interface cbs_result_writer_if #(
  parameter int ACC_W = cbs_pkg::ACC_W,
  parameter int SC_W = cbs_pkg::SC_W,
  parameter int ADDR_W = cbs_pkg::ADDR_W,
  parameter int PIX_W = cbs_pkg::PIX_W
);
  logic start;
  logic [ADDR_W-1:0] base_addr;
  logic signed [SC_W-1:0] bn_scale;
  logic signed [ACC_W-1:0] bn_shift;
  logic in_valid;
  logic in_ready;
  logic signed [ACC_W-1:0] in_data;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0] mem_wdata;
  logic busy;
  logic frame_done;
  modport master (
    output start, base_addr, bn_scale, bn_shift, in_valid, in_data,
    input in_ready, mem_we, mem_addr, mem_wdata, busy, frame_done
  );
  modport slave (
    input start, base_addr, bn_scale, bn_shift, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, frame_done
  );
endinterface

// File: rtl/cbs_wb_quant.sv
// cbs_wb_quant: 3-stage BN scale, round/shift, activation and 8-bit saturation (leaky when CBS_WB_LEAKY_EN)
module cbs_wb_quant import cbs_pkg::*; #(
  parameter int ACC_W = cbs_pkg::ACC_W,
  parameter int SC_W = cbs_pkg::SC_W,
  parameter int PIX_W = cbs_pkg::PIX_W
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic signed [ACC_W-1:0] in_data,
  input  logic signed [SC_W-1:0] bn_scale,
  input  logic signed [ACC_W-1:0] bn_shift,
  output logic out_valid,
  output logic [PIX_W-1:0] out_data,
  output logic pend
);
  localparam int PW = ACC_W + SC_W;
  logic signed [PW-1:0] prod, v, act;
  logic v1, v2;
  assign pend = v1 | v2;
  // activation on the shifted value; positive path is identical in both builds
  always_comb begin
`ifdef CBS_WB_LEAKY_EN
    act = v[PW-1] ? v >>> 3 : v;
`else
    act = v[PW-1] ? '0 : v;
`endif
  end
  // S1 multiply, S2 round-half-up shift plus offset, S3 clamp to unsigned pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {v1, v2, out_valid} <= '0;
      prod <= '0;
      v <= '0;
      out_data <= '0;
    end else begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      prod <= PW'(in_data) * PW'(bn_scale);
      v <= ((prod + PW'(128)) >>> 8) + PW'(bn_shift);
      out_data <= act[PW-1] ? '0 : act > PW'(PIX_MAX) ? PIX_W'(PIX_MAX) : act[PIX_W-1:0];
    end
  end
endmodule

// File: rtl/cbs_result_writer.sv
// cbs_result_writer: frame FSM and raster write addressing around the cbs_wb_quant pipeline
module cbs_result_writer import cbs_pkg::*; #(
  parameter int IMG_W = cbs_pkg::IMG_W,
  parameter int IMG_H = cbs_pkg::IMG_H
) (
  input logic clk,
  input logic reset,
  cbs_result_writer_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  wb_state_t state, nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [ADDR_W-1:0] addr, a1, a2;
  logic xfer, last, pend, col_end;
  assign bus.in_ready = state == RUN;
  assign bus.busy = state == RUN || state == FLUSH;
  assign bus.frame_done = state == DONE;
  assign xfer = bus.in_valid && bus.in_ready;
  assign col_end = col == CW'(IMG_W - 1);
  assign last = col_end && row == RW'(IMG_H - 1);
  // next state: frame start, last accepted pixel, pipeline drained, one-cycle done
  always_comb begin
    nxt = state;
    nxt = state == IDLE && bus.start ? RUN :
          state == RUN && xfer && last ? FLUSH :
          state == FLUSH && !pend ? DONE :
          state == DONE ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  // raster counters; the linear address advances by one per pixel, same as base + row*IMG_W + col
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
      addr <= '0;
    end else if (state == IDLE && bus.start) begin
      row <= '0;
      col <= '0;
      addr <= bus.base_addr;
    end else if (xfer) begin
      col <= col_end ? '0 : col + 1'b1;
      row <= col_end ? row + 1'b1 : row;
      addr <= addr + 1'b1;
    end
  end
  // address delay line matching the three quantiser stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1 <= '0;
      a2 <= '0;
      bus.mem_addr <= '0;
    end else begin
      a1 <= addr;
      a2 <= a1;
      bus.mem_addr <= a2;
    end
  end
  cbs_wb_quant #(.ACC_W(ACC_W), .SC_W(SC_W), .PIX_W(PIX_W)) u_quant (
    .clk(clk),
    .reset(reset),
    .in_valid(xfer),
    .in_data(bus.in_data),
    .bn_scale(bus.bn_scale),
    .bn_shift(bus.bn_shift),
    .out_valid(bus.mem_we),
    .out_data(bus.mem_wdata),
    .pend(pend)
  );
endmodule

// File: tb/tb_cbs_result_writer.sv
// tb_cbs_result_writer: randomized frames on a 4x3 map checked against a transfer-ordered reference model
module tb_cbs_result_writer;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  cbs_result_writer_if bus ();
  cbs_result_writer #(.IMG_W(4), .IMG_H(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {int c; logic [24:0] a; logic [7:0] d;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;
  int n = 0, nwr = 0, nfd = 0, last_we = 0;
  logic [24:0] fbase = '0;
  logic [7:0] wrd[16];
  logic signed [23:0] dat[12];
  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ref_pix(input longint x, input longint s, input longint h);
    longint v;
    v = ((x * s + 128) >>> 8) + h;
`ifdef CBS_WB_LEAKY_EN
    if (v < 0) v = v >>> 3;
`else
    if (v < 0) v = 0;
`endif
    return v < 0 ? 8'd0 : v > 255 ? 8'd255 : 8'(v);
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      nwr = 0;
      check("we_in_reset", bus.mem_we, 0);
    end else begin
      if (bus.start && !bus.busy && !bus.frame_done) begin
        fbase = bus.base_addr;
        n = 0;
        nwr = 0;
        nfd = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{cyc + 3, fbase + 25'(n), ref_pix(bus.in_data, bus.bn_scale, bus.bn_shift)});
        n++;
      end
      if (bus.mem_we) begin
        if (q.size() == 0) check("unexpected_we", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("we_cycle", cyc, e.c);
          check("we_addr", bus.mem_addr, e.a);
          check("we_data", bus.mem_wdata, e.d);
        end
        if (nwr < 16) wrd[nwr] = bus.mem_wdata;
        nwr++;
        last_we = cyc;
      end
      if (bus.frame_done) begin
        nfd++;
        check("done_after_last_we", cyc, last_we + 1);
      end
    end
  end
  task automatic frame(input logic [24:0] b, input logic signed [15:0] s, input logic signed [23:0] h,
                       input int gp, input bit ms);
    bit ok;
    int w;
    @(posedge clk); #1;
    bus.bn_scale = s;
    bus.bn_shift = h;
    bus.base_addr = b;
    bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    for (int k = 0; k < 12; k++) begin
      for (int g = 0; g < 4 && $urandom_range(0, 99) < gp; g++) begin
        bus.in_valid = 0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1;
      bus.in_data = dat[k];
      if (ms && k == 6) begin
        bus.start = 1;
        bus.base_addr = b + 25'd7;
      end
      w = 0;
      do begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk); #1;
        bus.start = 0;
        w++;
      end while (!ok && w < 20);
      if (!ok) check("ready_timeout", 0, 1);
    end
    bus.in_data = 0;
    w = 0;
    do begin
      @(negedge clk);
      ok = bus.frame_done;
      w++;
    end while (!ok && w < 30);
    check("frame_done_seen", ok, 1);
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(negedge clk);
    check("busy_after", bus.busy, 0);
    check("done_pulse_len", bus.frame_done, 0);
    check("ready_after", bus.in_ready, 0);
    check("writes", nwr, 12);
    check("done_pulses", nfd, 1);
    check("drained", q.size(), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int t;
    bus.start = 0;
    bus.base_addr = 25'd100;
    bus.bn_scale = 16'sh0100;
    bus.bn_shift = 0;
    bus.in_valid = 0;
    bus.in_data = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1;
      bus.in_data = 24'(i + 1);
      @(posedge clk); #1;
      bus.in_valid = 0;
    end
    repeat (6) @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_writes", nwr, 0);
    for (int k = 0; k < 12; k++) dat[k] = 24'(k);
    frame(25'd100, 16'sh0100, 0, 0, 0);
    for (int k = 0; k < 12; k++) check("seq_data", wrd[k], k);
    for (int k = 0; k < 12; k++) dat[k] = 24'(k);
    dat[0] = 300;
    dat[1] = -5;
    frame(25'd100, 16'sh0100, 0, 0, 0);
    check("sat_high", wrd[0], 255);
    check("sat_low", wrd[1], 0);
    for (int k = 0; k < 12; k++) dat[k] = 7;
    frame(25'd100, 16'sh0080, 0, 0, 0);
    check("round_half_up", wrd[0], 4);
    for (int k = 0; k < 12; k++) dat[k] = -40;
    frame(25'd100, 16'sh0100, 24'sd10, 0, 0);
    check("neg_v_clamped", wrd[0], 0);
    frame(25'd100, 16'sh0100, 24'sd50, 0, 0);
    check("offset_pos", wrd[0], 10);
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 12; k++) begin
        t = $urandom_range(0, 200000) - 100000;
        dat[k] = 24'(t);
      end
      t = $urandom_range(0, 1023) - 512;
      frame(f == 5 ? 25'h1FFFFFB : 25'd100, 16'(t), 24'($urandom_range(0, 4000)) - 24'sd2000, 40, f == 2);
    end
    @(posedge clk); #1;
    bus.bn_scale = 16'sh0100;
    bus.bn_shift = 0;
    bus.base_addr = 25'd100;
    bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1;
      bus.in_data = 24'(k + 1);
      @(posedge clk); #1;
    end
    reset = 1;
    bus.in_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (10) @(negedge clk);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_no_we", nwr, 0);
    for (int k = 0; k < 12; k++) dat[k] = 24'(k + 20);
    frame(25'd100, 16'sh0100, 0, 30, 0);
    for (int k = 0; k < 12; k++) check("post_rst_data", wrd[k], k + 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
